// File: rtl/mceliece_pkg.sv
// mceliece_pkg: Classic McEliece parameter tables, size helpers and the encryptor FSM encoding.
package mceliece_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD_E, S_KEY, S_OUT} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Width of a counter whose largest value is mx, never below one bit
    function automatic int cnt_w(input int mx);
        return clog2(mx + 1) > 0 ? clog2(mx + 1) : 1;
    endfunction

    function automatic int set_n(input int ps, input int n);
        return ps == 1 ? 3488 : ps == 2 ? 4608 : ps == 3 ? 6688 : ps == 4 ? 6960 : ps == 5 ? 8192 : n;
    endfunction

    function automatic int set_m(input int ps, input int m);
        return ps == 1 ? 12 : (ps >= 2 && ps <= 5) ? 13 : m;
    endfunction

    function automatic int set_t(input int ps, input int t);
        return ps == 1 ? 64 : ps == 2 ? 96 : ps == 3 ? 128 : ps == 4 ? 119 : ps == 5 ? 128 : t;
    endfunction
endpackage

// File: rtl/syndrome_serializer.sv
// syndrome_serializer: streams the syndrome register array as OUT_W-bit chunks, lowest chunk first.
module syndrome_serializer
    import mceliece_pkg::*;
#(
    parameter int W = 16,
    parameter int OUT_W = 8,
    parameter int NC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [W-1:0]     data,
    input  logic             c_ready,
    output logic [OUT_W-1:0] c_data,
    output logic             c_valid,
    output logic             c_last,
    output logic             fin
);
    localparam int CH = W / OUT_W;
    localparam int IW = cnt_w(CH - 1);

    logic [CH-1:0][OUT_W-1:0] chunk;
    logic [IW-1:0]            idx;

    assign chunk = data;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            idx <= '0;
        end else if (go) begin
            c_valid <= 1'b1;
            idx <= '0;
        end else if (fin) begin
            c_valid <= 1'b0;
        end else if (c_valid && c_ready) begin
            idx <= idx + 1'b1;
        end
    end

    always_comb begin
        c_last = c_valid && idx == IW'(NC - 1);
        fin = c_last && c_ready;
        c_data = c_valid ? chunk[idx] : '0;
    end
endmodule

// File: rtl/encrypt_syndrome_stream.sv
// encrypt_syndrome_stream: streaming Classic McEliece encryptor, C = [I_l | K]*e over GF(2).
// Rows are seeded from e[0..l-1]; each key column j with e[l+j]=1 is then folded in.
module encrypt_syndrome_stream
    import mceliece_pkg::*;
#(
    parameter int parameter_set = 2,
    parameter int N = 64,
    parameter int M = 4,
    parameter int T = 4,
    parameter int COL_W = 128,
    parameter int E_W = 128,
    parameter int OUT_W = 32,
    localparam int AW = cnt_w(ceil_div(set_n(parameter_set, N), E_W) - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             e_rd_en,
    output logic [AW-1:0]    e_addr,
    input  logic [E_W-1:0]   error,
    input  logic [COL_W-1:0] key_data,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [OUT_W-1:0] c_data,
    output logic             c_valid,
    input  logic             c_ready,
    output logic             c_last
);
    localparam int NN = set_n(parameter_set, N);
    localparam int L = set_m(parameter_set, M) * set_t(parameter_set, T);
    localparam int KK = NN - L;
    localparam int RB = ceil_div(L, COL_W);
    localparam int NC = ceil_div(L, OUT_W);
    localparam int RW = cnt_w(RB - 1);
    localparam int LW = cnt_w(RB);
    localparam int JW = cnt_w(KK - 1);
    localparam int BW = cnt_w(E_W - 1);
    localparam logic [COL_W-1:0] LAST_MASK = {COL_W{1'b1}} >> (COL_W - (L - (RB - 1) * COL_W));

    state_t                   state, state_nx;
    logic [RB-1:0][COL_W-1:0] s;
    logic [E_W-1:0]           ereg;
    logic                     ev, rd_q, hs, last_beat, fin;
    logic [LW-1:0]            ld_cnt;
    logic [RW-1:0]            r, cap;
    logic [JW-1:0]            j;
    logic [AW-1:0]            widx;
    logic [BW-1:0]            bofs;

    assign hs = key_valid && key_ready;
    assign last_beat = hs && r == RW'(RB - 1) && j == JW'(KK - 1);
    assign cap = RW'(ld_cnt - LW'(1));

    always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;

    always_comb
        state_nx = (state == S_IDLE && start) ? S_LOAD_E :
                   (state == S_LOAD_E && ld_cnt == LW'(RB)) ? S_KEY :
                   (state == S_KEY && last_beat) ? S_OUT :
                   (state == S_OUT && fin) ? S_IDLE : state;

    always_comb begin
        busy = state != S_IDLE;
        key_ready = state == S_KEY && ev;
        e_rd_en = (state == S_LOAD_E && ld_cnt < LW'(RB)) || (state == S_KEY && !ev && !rd_q);
        e_addr = state == S_LOAD_E ? AW'(ld_cnt) : state == S_KEY ? widx : '0;
    end

    // ereg holds the error word containing p = l + j; a refetch costs one read and one capture cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
            ereg <= '0;
            ev <= 1'b0;
            rd_q <= 1'b0;
            done <= 1'b0;
            ld_cnt <= '0;
            r <= '0;
            j <= '0;
            widx <= '0;
            bofs <= '0;
        end else begin
            rd_q <= e_rd_en;
            done <= fin;
            if (state == S_LOAD_E) begin
                ld_cnt <= ld_cnt == LW'(RB) ? '0 : ld_cnt + 1'b1;
                if (rd_q) s[cap] <= error & (cap == RW'(RB - 1) ? LAST_MASK : '1);
                ev <= 1'b0;
                r <= '0;
                j <= '0;
                widx <= AW'(L / E_W);
                bofs <= BW'(L % E_W);
            end
            if (state == S_KEY) begin
                if (rd_q) begin
                    ereg <= error;
                    ev <= 1'b1;
                end
                if (hs) begin
                    if (ereg[bofs]) s[r] <= s[r] ^ (key_data & (r == RW'(RB - 1) ? LAST_MASK : '1));
                    r <= r == RW'(RB - 1) ? '0 : r + 1'b1;
                    if (r == RW'(RB - 1)) begin
                        j <= j + 1'b1;
                        bofs <= bofs == BW'(E_W - 1) ? '0 : bofs + 1'b1;
                        if (bofs == BW'(E_W - 1)) begin
                            widx <= widx + 1'b1;
                            ev <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    syndrome_serializer #(.W(RB * COL_W), .OUT_W(OUT_W), .NC(NC)) u_ser (
        .clk(clk),
        .rst(rst),
        .go(last_beat),
        .data(s),
        .c_ready(c_ready),
        .c_data(c_data),
        .c_valid(c_valid),
        .c_last(c_last),
        .fin(fin)
    );
endmodule
